result_writer: RTL and testbench

RESULT_WRITER -- requirements
Module: result_writer

---
 rtl/result_writer.sv | 113 +++++++++++
 tb/tb_result_writer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_writer.sv
// Result writer: streams result words from the shift lane to memory.
// Optional stall counter enabled by defining RESULT_WRITER_STALL_CNT_EN.
module result_writer #(
  parameter int BUS_WIDTH   = 256,
  parameter int ADDR_WIDTH  = 32,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start_i,
  input  logic [ADDR_WIDTH-1:0]  base_addr_i,
  input  logic [COUNT_WIDTH-1:0] word_count_i,
  input  logic [BUS_WIDTH-1:0]   data_i,
  input  logic                   valid_i,
  output logic                   accepted_o,
  output logic                   mem_we_o,
  output logic [ADDR_WIDTH-1:0]  mem_addr_o,
  output logic [BUS_WIDTH-1:0]   mem_wdata_o,
  input  logic                   mem_ready_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [31:0]            stall_cnt_o
);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DONE
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] STRIDE =
    ADDR_WIDTH'(BUS_WIDTH / 8);

  state_t                 state;
  state_t                 state_nxt;
  logic [ADDR_WIDTH-1:0]  addr;
  logic [COUNT_WIDTH-1:0] remaining;
  logic                   start_ok;
  logic                   mem_fire;
  logic                   slot_free;

  assign start_ok   = (state == IDLE) & start_i;
  assign mem_fire   = mem_we_o & mem_ready_i;
  assign slot_free  = ~mem_we_o | mem_ready_i;
  assign accepted_o = (state == WRITE) & valid_i &
                      (remaining != '0) & slot_free;
  assign busy_o     = (state != IDLE);
  assign done_o     = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start_i)
          state_nxt = (word_count_i != '0) ? WRITE : DONE;
      end
      WRITE: begin
        // leave only once the final request has drained
        if ((remaining == '0) && slot_free)
          state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr        <= '0;
      remaining   <= '0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else begin
      if (start_ok && (word_count_i != '0)) begin
        addr      <= base_addr_i;
        remaining <= word_count_i;
      end
      if (accepted_o) begin
        mem_we_o    <= 1'b1;
        mem_addr_o  <= addr;
        mem_wdata_o <= data_i;
        addr        <= addr + STRIDE;
        remaining   <= remaining - 1'b1;
      end else if (mem_fire) begin
        mem_we_o <= 1'b0;
      end
    end
  end

`ifdef RESULT_WRITER_STALL_CNT_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (reset)
      stall_cnt <= '0;
    else if (start_ok)
      stall_cnt <= '0;
    else if (mem_we_o && !mem_ready_i && (stall_cnt != '1))
      stall_cnt <= stall_cnt + 32'd1;
  end

  assign stall_cnt_o = stall_cnt;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_result_writer.sv
// Directed bench for result_writer.
// Expects stall_cnt_o=3 after backpressure only with RESULT_WRITER_STALL_CNT_EN.
module tb_result_writer;

  logic         clk;
  logic         reset;
  logic         start_i;
  logic [31:0]  base_addr_i;
  logic [15:0]  word_count_i;
  logic [255:0] data_i;
  logic         valid_i;
  logic         accepted_o;
  logic         mem_we_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_wdata_o;
  logic         mem_ready_i;
  logic         busy_o;
  logic         done_o;
  logic [31:0]  stall_cnt_o;

  int vectors = 0;
  int miscompares = 0;
  int acc_cnt = 0;
  int acc_base;

  result_writer dut (
    .clk          (clk),
    .reset        (reset),
    .start_i      (start_i),
    .base_addr_i  (base_addr_i),
    .word_count_i (word_count_i),
    .data_i       (data_i),
    .valid_i      (valid_i),
    .accepted_o   (accepted_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_ready_i  (mem_ready_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .stall_cnt_o  (stall_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (accepted_o) acc_cnt <= acc_cnt + 1;

  function automatic logic [255:0] dat(input int k);
    logic [31:0] w;
    w = 32'hC0DE_0000 | 32'(k);
    return {8{w}};
  endfunction

  task automatic chk(input string tag,
                     input logic [255:0] obs,
                     input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic start_job(input logic [31:0] b,
                           input logic [15:0] n);
    start_i      = 1'b1;
    base_addr_i  = b;
    word_count_i = n;
  endtask

  initial begin
    reset        = 1'b1;
    start_i      = 1'b0;
    base_addr_i  = '0;
    word_count_i = '0;
    data_i       = '0;
    valid_i      = 1'b0;
    mem_ready_i  = 1'b0;
    step();
    step();
    reset = 1'b0;
    valid_i = 1'b1;
    settle();
    chk("rst_we", 256'(mem_we_o), 256'd0);
    chk("rst_addr", 256'(mem_addr_o), 256'd0);
    chk("rst_wdata", mem_wdata_o, 256'd0);
    chk("rst_busy", 256'(busy_o), 256'd0);
    chk("rst_done", 256'(done_o), 256'd0);
    chk("rst_acc", 256'(accepted_o), 256'd0);
    chk("rst_stall", 256'(stall_cnt_o), 256'd0);

    // basic: 4 words at 1 word/cycle
    mem_ready_i = 1'b1;
    start_job(32'h1000, 16'd4);
    data_i = dat(0);
    settle();
    chk("b_idle_acc", 256'(accepted_o), 256'd0);
    step();
    start_i = 1'b0;
    settle();
    chk("b_busy", 256'(busy_o), 256'd1);
    chk("b_acc0", 256'(accepted_o), 256'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      data_i = dat(i + 1);
      settle();
      chk("b_we", 256'(mem_we_o), 256'd1);
      chk("b_addr", 256'(mem_addr_o), 256'(32'h1000 + 32'(i) * 32));
      chk("b_wdata", mem_wdata_o, dat(i));
      chk("b_acc", 256'(accepted_o), (i < 3) ? 256'd1 : 256'd0);
      chk("b_done_lo", 256'(done_o), 256'd0);
    end
    step();
    settle();
    chk("b_done", 256'(done_o), 256'd1);
    chk("b_we_clr", 256'(mem_we_o), 256'd0);
    chk("b_acc_done", 256'(accepted_o), 256'd0);
    step();
    settle();
    chk("b_done_end", 256'(done_o), 256'd0);
    chk("b_idle", 256'(busy_o), 256'd0);

    // backpressure on the second word
    start_job(32'h2000, 16'd3);
    data_i = dat(16);
    step();
    start_i = 1'b0;
    step();
    data_i = dat(17);
    settle();
    chk("p_addr0", 256'(mem_addr_o), 256'h2000);
    step();
    mem_ready_i = 1'b0;
    data_i = dat(18);
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("p_acc", 256'(accepted_o), 256'd0);
      chk("p_we", 256'(mem_we_o), 256'd1);
      chk("p_addr", 256'(mem_addr_o), 256'h2020);
      chk("p_wdata", mem_wdata_o, dat(17));
      step();
    end
    mem_ready_i = 1'b1;
    settle();
    chk("p_acc_rel", 256'(accepted_o), 256'd1);
    step();
    settle();
    chk("p_addr2", 256'(mem_addr_o), 256'h2040);
    chk("p_wdata2", mem_wdata_o, dat(18));
    step();
    settle();
    chk("p_done", 256'(done_o), 256'd1);
`ifdef RESULT_WRITER_STALL_CNT_EN
    chk("p_stall", 256'(stall_cnt_o), 256'd3);
`else
    chk("p_stall", 256'(stall_cnt_o), 256'd0);
`endif
    step();

    // zero count: straight to DONE
    start_job(32'h3000, 16'd0);
    step();
    start_i = 1'b0;
    settle();
    chk("z_done", 256'(done_o), 256'd1);
    chk("z_busy", 256'(busy_o), 256'd1);
    chk("z_we", 256'(mem_we_o), 256'd0);
    chk("z_acc", 256'(accepted_o), 256'd0);
    chk("z_stall_clr", 256'(stall_cnt_o), 256'd0);
    step();
    settle();
    chk("z_busy_end", 256'(busy_o), 256'd0);
    chk("z_done_end", 256'(done_o), 256'd0);
    chk("z_we_end", 256'(mem_we_o), 256'd0);

    // address wrap
    start_job(32'hFFFF_FFE0, 16'd2);
    step();
    start_i = 1'b0;
    step();
    settle();
    chk("w_addr0", 256'(mem_addr_o), 256'hFFFF_FFE0);
    step();
    settle();
    chk("w_addr1", 256'(mem_addr_o), 256'h0);
    chk("w_we1", 256'(mem_we_o), 256'd1);
    step();
    settle();
    chk("w_done", 256'(done_o), 256'd1);
    step();

    // reset after 2 of 5 words
    start_job(32'h3000, 16'd5);
    step();
    start_i = 1'b0;
    step();
    step();
    settle();
    chk("r_addr1", 256'(mem_addr_o), 256'h3020);
    reset = 1'b1;
    step();
    settle();
    chk("r_we", 256'(mem_we_o), 256'd0);
    chk("r_busy", 256'(busy_o), 256'd0);
    chk("r_done", 256'(done_o), 256'd0);
    chk("r_acc", 256'(accepted_o), 256'd0);
    chk("r_addr", 256'(mem_addr_o), 256'd0);
    reset = 1'b0;
    step();
    settle();
    chk("r_done2", 256'(done_o), 256'd0);
    chk("r_busy2", 256'(busy_o), 256'd0);
    start_job(32'h4000, 16'd1);
    data_i = dat(32);
    step();
    start_i = 1'b0;
    step();
    settle();
    chk("r_addr_new", 256'(mem_addr_o), 256'h4000);
    chk("r_wdata_new", mem_wdata_o, dat(32));
    chk("r_acc_new", 256'(accepted_o), 256'd0);
    step();
    settle();
    chk("r_done_new", 256'(done_o), 256'd1);
    step();

    // start while busy plus surplus valid data
    acc_base = acc_cnt;
    start_job(32'h5000, 16'd2);
    data_i = dat(48);
    step();
    start_job(32'h9000, 16'd7);
    step();
    start_i = 1'b0;
    settle();
    chk("s_addr0", 256'(mem_addr_o), 256'h5000);
    step();
    settle();
    chk("s_addr1", 256'(mem_addr_o), 256'h5020);
    chk("s_acc_over", 256'(accepted_o), 256'd0);
    step();
    settle();
    chk("s_done", 256'(done_o), 256'd1);
    step();
    step();
    settle();
    chk("s_idle", 256'(busy_o), 256'd0);
    chk("s_count", 256'(acc_cnt - acc_base), 256'd2);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
